audio_fetch_arbiter: RTL and testbench

AUDIO_FETCH_ARBITER -- requirements
Module: audio_fetch_arbiter

---
 rtl/audio_fetch_arbiter.sv | 143 ++++++++++++++
 tb/tb_audio_fetch_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// audio_fetch_arbiter
//
// Shares one AXI-Lite read master among NUM_CHANNELS audio fetch requesters.
// A round-robin arbiter picks one requester at a time. Only one AXI read is
// outstanding at any moment. The read data is returned to the winning channel
// through a one-cycle response pulse.
//
// Handshake semantics (single statement for all interfaces):
//   A transfer happens in the cycle where both valid and ready are high.
//   On the channel request side, the channel holds ch_req_valid and
//   ch_req_addr until it sees ch_req_ready, which is a one-cycle one-hot
//   accept pulse. The channel response side has no ready: ch_rsp_valid is a
//   one-cycle one-hot pulse that the channel must consume in that cycle.
//   The AXI AR and R channels follow standard AXI valid/ready rules.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   ch_req_valid/addr     per-channel read requests (addr packed i*ADDR_WIDTH)
//   ch_req_ready          one-hot accept pulse
//   ch_rsp_valid          one-hot response pulse
//   ch_rsp_data/resp      shared response payload, held until next capture
//   m_axil_ar*            AXI-Lite read address channel (master side)
//   m_axil_r*             AXI-Lite read data channel (master side)
// -----------------------------------------------------------------------------
module audio_fetch_arbiter #(
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_CHANNELS-1:0]          ch_req_valid,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_req_addr,
    output logic [NUM_CHANNELS-1:0]          ch_req_ready,
    output logic [NUM_CHANNELS-1:0]          ch_rsp_valid,
    output logic [DATA_WIDTH-1:0]            ch_rsp_data,
    output logic [1:0]                       ch_rsp_resp,
    output logic [ADDR_WIDTH-1:0]            m_axil_araddr,
    output logic [2:0]                       m_axil_arprot,
    output logic                             m_axil_arvalid,
    input  logic                             m_axil_arready,
    input  logic [DATA_WIDTH-1:0]            m_axil_rdata,
    input  logic [1:0]                       m_axil_rresp,
    input  logic                             m_axil_rvalid,
    output logic                             m_axil_rready
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       winner;
    logic                   winner_found;
    logic                   accept;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [1:0]             resp_q;

    // Round-robin search. The offsets are walked from the farthest to the
    // nearest, so the nearest requester after last_grant is the one that
    // remains assigned at the end.
    always_comb begin
        int idx;
        idx          = 0;
        winner       = last_grant;
        winner_found = 1'b0;
        for (int off = NUM_CHANNELS; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_CHANNELS;
            if (ch_req_valid[idx]) begin
                winner       = IDX_W'(idx);
                winner_found = 1'b1;
            end
        end
    end

    // Requests are only looked at in IDLE. The reset term keeps the
    // combinational accept pulse quiet while reset is held.
    assign accept = (state == IDLE) && winner_found && !areset;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (winner_found)   state_next = ADDR;
            ADDR:    if (m_axil_arready) state_next = DATA;
            DATA:    if (m_axil_rvalid)  state_next = RESP;
            RESP:                        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_CHANNELS - 1);
            grant      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            resp_q     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                grant  <= winner;
                addr_q <= ch_req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if ((state == DATA) && m_axil_rvalid) begin
                data_q <= m_axil_rdata;
                resp_q <= m_axil_rresp;
            end
            if (state == RESP) begin
                last_grant <= grant;
            end
        end
    end

    always_comb begin
        ch_req_ready = '0;
        ch_rsp_valid = '0;
        if (accept) begin
            ch_req_ready[winner] = 1'b1;
        end
        if ((state == RESP) && !areset) begin
            ch_rsp_valid[grant] = 1'b1;
        end
    end

    assign m_axil_arvalid = (state == ADDR) && !areset;
    assign m_axil_araddr  = m_axil_arvalid ? addr_q : '0;
    assign m_axil_rready  = (state == DATA) && !areset;
    assign m_axil_arprot  = 3'b000;
    assign ch_rsp_data    = data_q;
    assign ch_rsp_resp    = resp_q;

endmodule

// File: tb/tb_audio_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_audio_fetch_arbiter
//
// Bench for audio_fetch_arbiter. It applies a table of directed transactions,
// a hand-written reset-in-DATA sequence, and randomized transactions. The
// randomized transactions are predicted by a round-robin reference model and
// by latency arithmetic (3 + address wait + data wait).
// -----------------------------------------------------------------------------
module tb_audio_fetch_arbiter;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              aclk = 1'b0;
    logic              areset;
    logic [N-1:0]      ch_req_valid;
    logic [N*AW-1:0]   ch_req_addr;
    logic [N-1:0]      ch_req_ready;
    logic [N-1:0]      ch_rsp_valid;
    logic [DW-1:0]     ch_rsp_data;
    logic [1:0]        ch_rsp_resp;
    logic [AW-1:0]     m_axil_araddr;
    logic [2:0]        m_axil_arprot;
    logic              m_axil_arvalid;
    logic              m_axil_arready;
    logic [DW-1:0]     m_axil_rdata;
    logic [1:0]        m_axil_rresp;
    logic              m_axil_rvalid;
    logic              m_axil_rready;

    // clock / reset
    always #5 aclk = ~aclk;

    audio_fetch_arbiter #(
        .NUM_CHANNELS (N),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .ch_req_valid   (ch_req_valid),
        .ch_req_addr    (ch_req_addr),
        .ch_req_ready   (ch_req_ready),
        .ch_rsp_valid   (ch_rsp_valid),
        .ch_rsp_data    (ch_rsp_data),
        .ch_rsp_resp    (ch_rsp_resp),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    typedef struct {
        bit          rst;
        logic [N-1:0] mask;
        int          ar_w;
        int          r_w;
        logic [31:0] rd;
        logic [1:0]  rr;
        int          exp_ch;
        int          exp_lat;
    } vec_t;

    vec_t          vecs[16];
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] addr_tab[N];
    logic [DW-1:0] exp_q[$];
    int            model_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_addrs();
        for (int i = 0; i < N; i++) ch_req_addr[i*AW +: AW] = addr_tab[i];
    endtask

    // Round robin: nearest requester after last, with wrap-around.
    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(ch_req_ready), 64'h0);
        check({tag, "_rsp_valid"}, 64'(ch_rsp_valid), 64'h0);
        check({tag, "_rsp_data"},  64'(ch_rsp_data),  64'h0);
        check({tag, "_rsp_resp"},  64'(ch_rsp_resp),  64'h0);
        check({tag, "_arvalid"},   64'(m_axil_arvalid), 64'h0);
        check({tag, "_rready"},    64'(m_axil_rready),  64'h0);
        check({tag, "_araddr"},    64'(m_axil_araddr),  64'h0);
    endtask

    task automatic do_reset();
        ch_req_valid   = '0;
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b0;
        areset         = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        check_idle_outputs("reset");
        check("arprot", 64'(m_axil_arprot), 64'h0);
        areset     = 1'b0;
        model_last = N - 1;
        exp_q.delete();
    endtask

    // Driver + slave + per-cycle checks for one transaction.
    // The task is entered just after a falling edge, with the DUT in IDLE.
    task automatic run_txn(input logic [N-1:0] mask, input int ar_w, input int r_w,
                           input logic [31:0] rd, input logic [1:0] rr,
                           input int exp_ch, input int exp_lat);
        logic [N-1:0] exp_oh;
        int ar_cnt;
        int r_cnt;
        exp_oh = '0;
        exp_oh[exp_ch] = 1'b1;
        ar_cnt = 0;
        r_cnt  = 0;
        ch_req_valid = mask;
        for (int cyc = 0; cyc <= exp_lat; cyc++) begin
            m_axil_arready = 1'b0;
            m_axil_rvalid  = 1'b0;
            m_axil_rdata   = $urandom;
            m_axil_rresp   = 2'($urandom_range(0, 3));
            #1;
            if (cyc == 0) begin
                check("req_ready", 64'(ch_req_ready), 64'(exp_oh));
                exp_q.push_back(rd);
            end else if (ch_req_ready != '0) begin
                check("ready_outside_idle", 64'(ch_req_ready), 64'h0);
            end
            check("arvalid_window", 64'(m_axil_arvalid),
                  64'((cyc >= 1) && (cyc <= 1 + ar_w)));
            check("rready_window", 64'(m_axil_rready),
                  64'((cyc >= 2 + ar_w) && (cyc <= 2 + ar_w + r_w)));
            if (m_axil_arvalid) begin
                check("araddr", 64'(m_axil_araddr), 64'(addr_tab[exp_ch]));
                m_axil_arready = (ar_cnt == ar_w);
                ar_cnt++;
            end
            if (m_axil_rready) begin
                m_axil_rvalid = (r_cnt == r_w);
                if (m_axil_rvalid) begin
                    m_axil_rdata = rd;
                    m_axil_rresp = rr;
                end
                r_cnt++;
            end
            if (cyc == exp_lat) begin
                check("rsp_valid", 64'(ch_rsp_valid), 64'(exp_oh));
                check("rsp_resp", 64'(ch_rsp_resp), 64'(rr));
                if (exp_q.size() > 0) check("rsp_data", 64'(ch_rsp_data), 64'(exp_q.pop_front()));
            end else if (ch_rsp_valid != '0) begin
                check("rsp_early", 64'(ch_rsp_valid), 64'h0);
            end
            @(negedge aclk);
            if (cyc == 0) ch_req_valid[exp_ch] = 1'b0;
        end
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b0;
        #1;
        check("rsp_hold_data", 64'(ch_rsp_data), 64'(rd));
        check("rsp_pulse_one_cycle", 64'(ch_rsp_valid), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h01, 0, 0, 32'hDEADBEEF, 2'b00, 0, 3};
        vecs[1]  = '{1'b1, 8'hFF, 0, 0, 32'h1000_0001, 2'b00, 0, 3};
        for (int v = 2; v <= 9; v++) begin
            vecs[v] = '{1'b0, 8'hFF, 0, 0, 32'h1000_0000 + 32'(v), 2'b00, (v - 1) % N, 3};
        end
        vecs[10] = '{1'b0, 8'h02, 3, 2, 32'h1234_5678, 2'b00, 1, 8};
        vecs[11] = '{1'b0, 8'h02, 0, 0, 32'h0BAD_F00D, 2'b01, 1, 3};
        vecs[12] = '{1'b0, 8'h08, 0, 0, 32'h3333_3333, 2'b00, 3, 3};
        vecs[13] = '{1'b0, 8'h24, 0, 0, 32'h5555_5555, 2'b00, 5, 3};
        vecs[14] = '{1'b0, 8'h04, 0, 0, 32'h2222_2222, 2'b00, 2, 3};
        vecs[15] = '{1'b0, 8'h04, 1, 1, 32'hCAFE_0001, 2'b10, 2, 5};

        areset         = 1'b1;
        ch_req_valid   = '0;
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b0;
        m_axil_rdata   = '0;
        m_axil_rresp   = '0;
        for (int i = 0; i < N; i++) addr_tab[i] = 32'h10 + 32'(i) * 32'h100;
        drive_addrs();
        model_last = N - 1;

        // table-driven directed transactions
        for (int v = 0; v < 16; v++) begin
            if (vecs[v].rst) do_reset();
            run_txn(vecs[v].mask, vecs[v].ar_w, vecs[v].r_w, vecs[v].rd,
                    vecs[v].rr, vecs[v].exp_ch, vecs[v].exp_lat);
            model_last = vecs[v].exp_ch;
        end

        // reset while the read is in DATA: the access is abandoned
        ch_req_valid = 8'h04;
        #1;
        check("mid_accept", 64'(ch_req_ready), 64'h04);
        @(negedge aclk);
        ch_req_valid = '0;
        #1;
        check("mid_arvalid", 64'(m_axil_arvalid), 64'h1);
        m_axil_arready = 1'b1;
        @(negedge aclk);
        m_axil_arready = 1'b0;
        #1;
        check("mid_rready", 64'(m_axil_rready), 64'h1);
        areset = 1'b1;
        @(negedge aclk);
        #1;
        check_idle_outputs("mid_reset");
        areset = 1'b0;
        exp_q.delete();
        model_last = N - 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            #1;
            check("post_reset_no_rsp", 64'(ch_rsp_valid), 64'h0);
            check("post_reset_idle", 64'(m_axil_arvalid), 64'h0);
        end
        // Before the reset, last_grant was 2, so this mask would pick channel 3.
        // After the reset, channel 0 must be picked.
        run_txn(8'h09, 0, 0, 32'hA5A5_0000, 2'b00, 0, 3);
        model_last = 0;

        // randomized transactions against the round-robin model
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] mask;
            int           ar_w;
            int           r_w;
            int           ch;
            mask = N'($urandom_range(1, (1 << N) - 1));
            ar_w = $urandom_range(0, 3);
            r_w  = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) addr_tab[i] = $urandom;
            drive_addrs();
            ch = rr_pick(mask, model_last);
            run_txn(mask, ar_w, r_w, $urandom, 2'($urandom_range(0, 3)), ch, 3 + ar_w + r_w);
            model_last = ch;
        end

        ch_req_valid = '0;
        check("exp_q_drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
